// File: rtl/user_input_controller.sv
// Board input front end: 2-FF sync, tick-sampled debounce, per-button press/release/long-press FSM.
// Events land one cycle after the accepting tick; INPUT_AUTOREPEAT_EN adds auto-repeat presses.
module user_input_controller #(
  parameter int SAMPLE_PERIOD    = 100000,
  parameter int STABLE_SAMPLES   = 5,
  parameter int LONG_PRESS_TICKS = 1000,
  parameter int REPEAT_TICKS     = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] switchRaw,
  input  logic [3:0]  buttonRaw,
  output logic [14:0] switchStable,
  output logic        switchChanged,
  output logic [3:0]  buttonLevel,
  output logic [3:0]  buttonPress,
  output logic [3:0]  buttonRelease,
  output logic [3:0]  buttonLongPress,
  output logic        sampleTick
);

  localparam int NIN     = 19;
  localparam int PW      = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int CNT_MAX = (LONG_PRESS_TICKS > REPEAT_TICKS) ? LONG_PRESS_TICKS : REPEAT_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {RELEASED, PRESSED, LONG} btn_state_t;

  logic [NIN-1:0] raw, sync1, sync2, stable, accept;
  logic [3:0]     deb_cnt [NIN];
  logic [PW-1:0]  pre_cnt;
  logic [3:0]     rise, fall;
  btn_state_t     state    [4];
  logic [CW-1:0]  hold_cnt [4];
`ifdef INPUT_AUTOREPEAT_EN
  logic [CW-1:0]  rep_cnt  [4];
`endif

  assign raw          = {buttonRaw, switchRaw};
  assign switchStable = stable[14:0];
  assign buttonLevel  = stable[18:15];
  assign sampleTick   = (pre_cnt == PW'(SAMPLE_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || sampleTick) pre_cnt <= '0;
    else                     pre_cnt <= pre_cnt + 1'b1;
  end

  // A bit is accepted on the tick that completes its STABLE_SAMPLES-th consecutive mismatch.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NIN; i++)
      accept[i] = sampleTick && (sync2[i] != stable[i]) &&
                  (deb_cnt[i] == 4'(STABLE_SAMPLES - 1));
  end

  assign rise = accept[18:15] & sync2[18:15];
  assign fall = accept[18:15] & ~sync2[18:15];

  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < NIN; i++) deb_cnt[i] <= '0;
    end else if (sampleTick) begin
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      switchChanged   <= 1'b0;
      buttonPress     <= '0;
      buttonRelease   <= '0;
      buttonLongPress <= '0;
      for (int b = 0; b < 4; b++) begin
        state[b]    <= RELEASED;
        hold_cnt[b] <= '0;
`ifdef INPUT_AUTOREPEAT_EN
        rep_cnt[b]  <= '0;
`endif
      end
    end else begin
      switchChanged   <= |accept[14:0];
      buttonPress     <= '0;
      buttonRelease   <= '0;
      buttonLongPress <= '0;
      for (int b = 0; b < 4; b++) begin
        case (state[b])
          RELEASED: begin
            if (rise[b]) begin
              state[b]       <= PRESSED;
              buttonPress[b] <= 1'b1;
              hold_cnt[b]    <= '0;
            end
          end
          PRESSED: begin
            // A falling edge takes priority over a long-press reached on the same tick.
            if (fall[b]) begin
              state[b]         <= RELEASED;
              buttonRelease[b] <= 1'b1;
            end else if (sampleTick) begin
              hold_cnt[b] <= hold_cnt[b] + 1'b1;
              if (hold_cnt[b] == CW'(LONG_PRESS_TICKS - 1)) begin
                state[b]           <= LONG;
                buttonLongPress[b] <= 1'b1;
`ifdef INPUT_AUTOREPEAT_EN
                rep_cnt[b]         <= '0;
`endif
              end
            end
          end
          LONG: begin
            if (fall[b]) begin
              state[b]         <= RELEASED;
              buttonRelease[b] <= 1'b1;
            end
`ifdef INPUT_AUTOREPEAT_EN
            else if (sampleTick) begin
              if (rep_cnt[b] == CW'(REPEAT_TICKS - 1)) begin
                rep_cnt[b]     <= '0;
                buttonPress[b] <= 1'b1;
              end else begin
                rep_cnt[b] <= rep_cnt[b] + 1'b1;
              end
            end
`endif
          end
          default: state[b] <= RELEASED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_user_input_controller.sv
// Scoreboard bench for user_input_controller: expected events (kind, index, tick) queued at stimulus time.
module tb_user_input_controller;

  localparam int SP = 4;
  localparam int SS = 3;
  localparam int LP = 8;
  localparam int RT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] switch_raw = '0;
  logic [3:0]  button_raw = '0;
  logic [14:0] switch_stable;
  logic        switch_changed;
  logic [3:0]  button_level, button_press, button_release, button_long;
  logic        sample_tick;

  user_input_controller #(
    .SAMPLE_PERIOD(SP), .STABLE_SAMPLES(SS), .LONG_PRESS_TICKS(LP), .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk), .reset(reset), .switchRaw(switch_raw), .buttonRaw(button_raw),
    .switchStable(switch_stable), .switchChanged(switch_changed), .buttonLevel(button_level),
    .buttonPress(button_press), .buttonRelease(button_release), .buttonLongPress(button_long),
    .sampleTick(sample_tick)
  );

  always #5 clk = ~clk;

  // kind: 0 switch change, 1 press, 2 release, 3 long press
  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  idx;
    logic [31:0] stamp;
  } ev_t;

  ev_t exp_q[$];
  int  tick_cnt = 0;
  int  chk_cnt = 0;
  int  pass_cnt = 0;

  task push_ev(input int kind, input int idx, input int stamp);
    exp_q.push_back('{kind: 2'(kind), idx: 2'(idx), stamp: 32'(stamp)});
  endtask

  // Events are stamped with the number of the tick that caused them.
  task monitor;
    ev_t         e;
    logic [12:0] ev;
    int          k, i;
    forever begin
      @(negedge clk);
      ev = {button_long, button_release, button_press, switch_changed};
      for (int j = 0; j < 13; j++) begin
        if (ev[j] === 1'b1) begin
          k = (j == 0) ? 0 : ((j - 1) / 4 + 1);
          i = (j == 0) ? 0 : ((j - 1) % 4);
          chk_cnt++;
          if (exp_q.size() == 0) begin
            $display("FAIL event: got kind=%0d idx=%0d tick=%0d, required no event", k, i, tick_cnt);
          end else begin
            e = exp_q.pop_front();
            if (e.kind !== 2'(k) || e.idx !== 2'(i) || e.stamp !== 32'(tick_cnt))
              $display("FAIL event: got kind=%0d idx=%0d tick=%0d, required kind=%0d idx=%0d tick=%0d",
                       k, i, tick_cnt, e.kind, e.idx, e.stamp);
            else
              pass_cnt++;
          end
        end
      end
      if (sample_tick === 1'b1) tick_cnt++;
    end
  endtask

  // Returns in the tick cycle (1 ns after the edge) with that tick's number.
  task wait_tick(output int t);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (sample_tick !== 1'b1 && n < 4 * SP);
    chk_cnt++;
    if (sample_tick !== 1'b1)
      $display("FAIL tick_timeout: sampleTick=%b, required 1 within %0d cycles", sample_tick, 4 * SP);
    else
      pass_cnt++;
    t = tick_cnt + 1;
  endtask

  task wait_ticks(input int n);
    int t;
    repeat (n) wait_tick(t);
  endtask

  task test_reset;
    reset = 1'b1;
    switch_raw = 15'h0005;
    button_raw = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if ({switch_stable, switch_changed, button_level, button_press, button_release, button_long, sample_tick} !== '0)
      $display("FAIL reset_outputs: got stable=%h lvl=%h ev=%b%h%h%h tick=%b, required all 0",
               switch_stable, button_level, switch_changed, button_press, button_release, button_long, sample_tick);
    else
      pass_cnt++;
  endtask

  task test_switch_settle;
    logic [15:0] pat;
    int base;
    reset = 1'b0;
    base = tick_cnt;
    push_ev(0, 0, base + 3);
    pat = '0;
    for (int i = 1; i < 16; i++) begin
      @(posedge clk); #1;
      pat[i] = sample_tick;
    end
    chk_cnt++;
    if (pat !== 16'h8888) $display("FAIL tick_pattern: got %h, required 8888", pat);
    else pass_cnt++;
    chk_cnt++;
    if (switch_stable !== 15'h0005) $display("FAIL switch_settle: got %h, required 0005", switch_stable);
    else pass_cnt++;
    wait_ticks(2);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL switch_changed_missing: got %0d pending, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task test_glitch;
    int t;
    wait_tick(t);
    button_raw[0] = 1'b1;
    wait_ticks(2);
    button_raw[0] = 1'b0;
    wait_ticks(4);
    chk_cnt++;
    if (button_level !== 4'b0000) $display("FAIL glitch_level: got %b, required 0000", button_level);
    else pass_cnt++;
  endtask

  task test_long_press;
    int t0, t;
    wait_tick(t0);
    button_raw[1] = 1'b1;
    push_ev(1, 1, t0 + SS);
    push_ev(3, 1, t0 + SS + LP);
`ifdef INPUT_AUTOREPEAT_EN
    for (int r = SS + LP + RT; r < 20 + SS; r += RT) push_ev(1, 1, t0 + r);
`endif
    for (int k = 0; k < 20; k++) begin
      wait_tick(t);
      if (k == 9) begin
        chk_cnt++;
        if (button_level !== 4'b0010) $display("FAIL long_hold_level: got %b, required 0010", button_level);
        else pass_cnt++;
      end
    end
    button_raw[1] = 1'b0;
    push_ev(2, 1, t + SS);
    wait_ticks(5);
    chk_cnt++;
    if (exp_q.size() != 0 || button_level !== 4'b0000)
      $display("FAIL long_press_events: got %0d pending lvl=%b, required 0 pending lvl=0000", exp_q.size(), button_level);
    else pass_cnt++;
  endtask

  task test_reset_mid;
    int t, base;
    wait_tick(t);
    button_raw[2] = 1'b1;
    wait_ticks(2);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if ({switch_stable, switch_changed, button_level, button_press, button_release, button_long, sample_tick} !== '0)
      $display("FAIL reset_mid_outputs: got stable=%h lvl=%h tick=%b, required all 0",
               switch_stable, button_level, sample_tick);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    base = tick_cnt;
    push_ev(0, 0, base + SS);
    push_ev(1, 2, base + SS);
    wait_ticks(5);
    chk_cnt++;
    if (button_level !== 4'b0100 || switch_stable !== 15'h0005)
      $display("FAIL reset_mid_recover: got lvl=%b sw=%h, required 0100 0005", button_level, switch_stable);
    else pass_cnt++;
    wait_tick(t);
    button_raw[2] = 1'b0;
    push_ev(2, 2, t + SS);
    wait_ticks(5);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL reset_mid_events: got %0d pending, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task test_back_to_back;
    int t, t2;
    wait_tick(t);
    switch_raw = 15'h7FFF;
    button_raw = 4'hF;
    push_ev(0, 0, t + SS);
    for (int b = 0; b < 4; b++) push_ev(1, b, t + SS);
    wait_ticks(SS);
    chk_cnt++;
    if (switch_stable !== 15'h0005 || button_level !== 4'h0)
      $display("FAIL b2b_before: got sw=%h lvl=%h, required 0005 0", switch_stable, button_level);
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if ({switch_stable, button_level, button_press, switch_changed} !== {15'h7FFF, 4'hF, 4'hF, 1'b1})
      $display("FAIL b2b_same_cycle: got sw=%h lvl=%h press=%h chg=%b, required 7fff f f 1",
               switch_stable, button_level, button_press, switch_changed);
    else pass_cnt++;
    wait_tick(t2);
    button_raw = 4'h0;
    for (int b = 0; b < 4; b++) push_ev(2, b, t2 + SS);
    wait_ticks(5);
    chk_cnt++;
    if (exp_q.size() != 0 || button_level !== 4'h0)
      $display("FAIL b2b_events: got %0d pending lvl=%h, required 0 pending lvl=0", exp_q.size(), button_level);
    else pass_cnt++;
  endtask

  task test_autorepeat;
    int t0, t;
    wait_tick(t0);
    button_raw[3] = 1'b1;
    push_ev(1, 3, t0 + SS);
    push_ev(3, 3, t0 + SS + LP);
`ifdef INPUT_AUTOREPEAT_EN
    push_ev(1, 3, t0 + SS + LP + RT);
    push_ev(1, 3, t0 + SS + LP + 2 * RT);
`endif
    for (int k = 0; k < 14; k++) wait_tick(t);
    button_raw[3] = 1'b0;
    push_ev(2, 3, t + SS);
    wait_ticks(5);
    chk_cnt++;
    if (exp_q.size() != 0 || button_level !== 4'h0)
      $display("FAIL autorepeat_events: got %0d pending lvl=%h, required 0 pending lvl=0", exp_q.size(), button_level);
    else pass_cnt++;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_switch_settle();
    test_glitch();
    test_long_press();
    test_reset_mid();
    test_back_to_back();
    test_autorepeat();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
